// File: rtl/neosd_cmd_arb.sv
// neosd_cmd_arb: two-requester round-robin arbiter in front of the SD command engine.
// A winning request is latched and handed to the engine. Its response is then tracked
// until the engine finishes, the command is aborted, or the tick budget runs out. The
// granted requester receives a one-cycle ack_o; tout_o qualifies that ack.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   tick_i               SD bit-clock enable (one clk_i cycle wide)
//   abort_i              abort the in-flight command
//   req_i[1:0]           per-requester request (level)
//   idx*_i/arg*_i/rmode*_i  command index / argument / response mode per requester
//   ack_o[1:0]           one-cycle completion pulse to the granted requester
//   tout_o               completion was timeout/abort (valid with ack_o only)
//   busy_o               a command is in flight
//   eng_commit_o, eng_idx_o, eng_arg_o, eng_rmode_o  command to the engine
//   eng_busy_i           engine executing
module neosd_cmd_arb #(
  parameter int unsigned TIMEOUT_TICKS = 128
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        tick_i,
  input  logic        abort_i,
  input  logic [1:0]  req_i,
  input  logic [5:0]  idx0_i,
  input  logic [5:0]  idx1_i,
  input  logic [31:0] arg0_i,
  input  logic [31:0] arg1_i,
  input  logic [1:0]  rmode0_i,
  input  logic [1:0]  rmode1_i,
  output logic [1:0]  ack_o,
  output logic        tout_o,
  output logic        busy_o,
  output logic        eng_commit_o,
  output logic [5:0]  eng_idx_o,
  output logic [31:0] eng_arg_o,
  output logic [1:0]  eng_rmode_o,
  input  logic        eng_busy_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ptr_q, ptr_d;      // requester favoured when both request
  logic        gnt_q, gnt_d;      // requester owning the current command
  logic [1:0]  ack_q, ack_d;
  logic        tout_q, tout_d;
  logic        busy_q, busy_d;
  logic        commit_q, commit_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] arg_q, arg_d;
  logic [1:0]  rmode_q, rmode_d;

  logic        win;
  logic        timeout;
  logic [1:0]  gnt_onehot;

  assign win        = (req_i == 2'b11) ? ptr_q : req_i[1];
  assign timeout    = ({16'd0, cnt_q} >= TIMEOUT_TICKS);
  assign gnt_onehot = gnt_q ? 2'b10 : 2'b01;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    ack_d    = 2'b00;
    tout_d   = 1'b0;
    busy_d   = busy_q;
    commit_d = commit_q;
    idx_d    = idx_q;
    arg_d    = arg_q;
    rmode_d  = rmode_q;

    if ((state_q == StIssue || state_q == StWait) && tick_i && cnt_q != 16'hffff) begin
      cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      StIdle: begin
        if (req_i != 2'b00) begin
          state_d  = StIssue;
          gnt_d    = win;
          idx_d    = win ? idx1_i : idx0_i;
          arg_d    = win ? arg1_i : arg0_i;
          rmode_d  = win ? rmode1_i : rmode0_i;
          commit_d = 1'b1;
          busy_d   = 1'b1;
          cnt_d    = '0;
        end
      end
      StIssue: begin
        // Abort/timeout win over the engine accepting the commit in the same cycle.
        if (abort_i || timeout) begin
          state_d  = StDone;
          commit_d = 1'b0;
          ack_d    = gnt_onehot;
          tout_d   = 1'b1;
        end else if (eng_busy_i) begin
          state_d  = StWait;
          commit_d = 1'b0;
        end
      end
      StWait: begin
        // A real engine completion beats an abort or timeout in the same cycle.
        if (!eng_busy_i) begin
          state_d = StDone;
          ack_d   = gnt_onehot;
        end else if (abort_i || timeout) begin
          state_d = StDone;
          ack_d   = gnt_onehot;
          tout_d  = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
        ptr_d   = ~gnt_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ptr_q    <= 1'b0;
      gnt_q    <= 1'b0;
      ack_q    <= 2'b00;
      tout_q   <= 1'b0;
      busy_q   <= 1'b0;
      commit_q <= 1'b0;
      idx_q    <= '0;
      arg_q    <= '0;
      rmode_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      gnt_q    <= gnt_d;
      ack_q    <= ack_d;
      tout_q   <= tout_d;
      busy_q   <= busy_d;
      commit_q <= commit_d;
      idx_q    <= idx_d;
      arg_q    <= arg_d;
      rmode_q  <= rmode_d;
    end
  end

  assign ack_o        = ack_q;
  assign tout_o       = tout_q;
  assign busy_o       = busy_q;
  assign eng_commit_o = commit_q;
  assign eng_idx_o    = idx_q;
  assign eng_arg_o    = arg_q;
  assign eng_rmode_o  = rmode_q;

endmodule

// File: tb/tb_neosd_cmd_arb.sv
// Self-checking bench for neosd_cmd_arb. Each command is described by when the engine
// raises/drops busy, when abort pulses and the tick density. The expected end of the
// command is the earliest of engine completion, abort or tick budget exhaustion,
// with completion winning ties. Grants follow a round-robin pointer model.
module tb_neosd_cmd_arb;
  localparam int unsigned TO = 128;
  localparam int NONE = 1000000;

  logic        clk_i, rstn_i, tick_i, abort_i, eng_busy_i;
  logic [1:0]  req_i, rmode0_i, rmode1_i, ack_o, eng_rmode_o;
  logic [5:0]  idx0_i, idx1_i, eng_idx_o;
  logic [31:0] arg0_i, arg1_i, eng_arg_o;
  logic        tout_o, busy_o, eng_commit_o;

  neosd_cmd_arb #(.TIMEOUT_TICKS(TO)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .tick_i(tick_i), .abort_i(abort_i), .req_i(req_i),
    .idx0_i(idx0_i), .idx1_i(idx1_i), .arg0_i(arg0_i), .arg1_i(arg1_i),
    .rmode0_i(rmode0_i), .rmode1_i(rmode1_i), .ack_o(ack_o), .tout_o(tout_o),
    .busy_o(busy_o), .eng_commit_o(eng_commit_o), .eng_idx_o(eng_idx_o),
    .eng_arg_o(eng_arg_o), .eng_rmode_o(eng_rmode_o), .eng_busy_i(eng_busy_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int   total = 0;
  int   bad   = 0;
  logic pri   = 1'b0;  // requester that wins when both request

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ack"}, ack_o, 0);
    chk({tag, "_tout"}, tout_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_commit"}, eng_commit_o, 0);
    chk({tag, "_idx"}, eng_idx_o, 0);
    chk({tag, "_arg"}, eng_arg_o, 0);
    chk({tag, "_rmode"}, eng_rmode_o, 0);
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      req_i      = 2'b00;
      abort_i    = 1'($urandom_range(0, 1));
      tick_i     = 1'($urandom_range(0, 1));
      eng_busy_i = 1'b0;
      cyc();
      chk("idle_busy", busy_o, 0);
      chk("idle_ack", ack_o, 0);
      chk("idle_tout", tout_o, 0);
      chk("idle_commit", eng_commit_o, 0);
    end
    abort_i = 1'b0;
  endtask

  // b: sample index at which eng_busy_i rises, e: sample at which it falls (e > b),
  // a: sample carrying abort_i, pct: tick probability in percent. Sample 0 is the
  // first clock edge after the commit edge.
  task automatic do_cmd(input logic [1:0] rq, input int b, input int e, input int a,
                        input int pct, input bit hold, input bit rnd);
    int w, tsum, s;
    bit ended, to;
    logic [5:0]  xi;
    logic [31:0] xa;
    logic [1:0]  xr;
    if (rnd) begin
      idx0_i = 6'($urandom); idx1_i = 6'($urandom);
      arg0_i = $urandom;     arg1_i = $urandom;
      rmode0_i = 2'($urandom); rmode1_i = 2'($urandom);
    end
    w  = (rq == 2'b11) ? int'(pri) : ((rq == 2'b10) ? 1 : 0);
    xi = (w == 1) ? idx1_i : idx0_i;
    xa = (w == 1) ? arg1_i : arg0_i;
    xr = (w == 1) ? rmode1_i : rmode0_i;
    req_i = rq; abort_i = 1'b0; eng_busy_i = 1'b0; tick_i = 1'($urandom_range(0, 1));
    cyc();
    chk("grant_commit", eng_commit_o, 1);
    chk("grant_busy", busy_o, 1);
    chk("grant_ack", ack_o, 0);
    chk("grant_idx", eng_idx_o, xi);
    chk("grant_arg", eng_arg_o, xa);
    chk("grant_rmode", eng_rmode_o, xr);
    tsum = 0; ended = 0; s = 0;
    while (!ended && s < 4000) begin
      req_i  = hold ? rq : 2'($urandom);
      idx0_i = 6'($urandom); idx1_i = 6'($urandom);
      arg0_i = $urandom;     arg1_i = $urandom;
      rmode0_i = 2'($urandom); rmode1_i = 2'($urandom);
      tick_i     = ($urandom_range(1, 100) <= pct);
      eng_busy_i = (s >= b && s < e);
      abort_i    = (s == a);
      ended = (s == e) || (s == a) || (tsum >= int'(TO));
      to    = (s != e);
      cyc();
      if (tick_i) tsum++;
      if (ended) begin
        chk("done_ack", ack_o, (w == 1) ? 32'd2 : 32'd1);
        chk("done_tout", tout_o, {31'd0, to});
        chk("done_commit", eng_commit_o, 0);
        chk("done_busy", busy_o, 1);
      end else begin
        chk("run_ack", ack_o, 0);
        chk("run_tout", tout_o, 0);
        chk("run_commit", eng_commit_o, (s < b) ? 32'd1 : 32'd0);
        chk("run_busy", busy_o, 1);
      end
      chk("stable_idx", eng_idx_o, xi);
      chk("stable_arg", eng_arg_o, xa);
      chk("stable_rmode", eng_rmode_o, xr);
      s++;
    end
    if (!ended) chk("cmd_never_ended", ack_o, (w == 1) ? 32'd2 : 32'd1);
    req_i = hold ? rq : 2'b00; abort_i = 1'b0; eng_busy_i = 1'b0; tick_i = 1'b0;
    cyc();
    chk("post_ack", ack_o, 0);
    chk("post_tout", tout_o, 0);
    chk("post_busy", busy_o, 0);
    chk("post_commit", eng_commit_o, 0);
    pri = (w == 1) ? 1'b0 : 1'b1;
  endtask

  initial begin
    rstn_i = 1'b0; tick_i = 1'b0; abort_i = 1'b0; eng_busy_i = 1'b0; req_i = 2'b00;
    idx0_i = '0; idx1_i = '0; arg0_i = '0; arg1_i = '0; rmode0_i = '0; rmode1_i = '0;
    #12;
    chk_all_zero("reset");
    cyc();
    rstn_i = 1'b1;
    idle_gap(3);

    // Basic command from requester 0.
    idx0_i = 6'd17; arg0_i = 32'h0000_1000; rmode0_i = 2'd1;
    idx1_i = 6'd5;  arg1_i = 32'hdead_beef; rmode1_i = 2'd2;
    do_cmd(2'b01, 2, 60, NONE, 100, 1'b0, 1'b0);

    // Bring pointer back to requester 0, then contention held over three commands.
    do_cmd(2'b10, 1, 5, NONE, 50, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) do_cmd(2'b11, 1, 10, NONE, 50, 1'b1, 1'b1);

    // Engine never answers: timeout after TO ticks.
    do_cmd(2'b01, NONE, NONE, NONE, 100, 1'b0, 1'b1);
    // Abort while waiting, then abort coinciding with engine completion.
    do_cmd(2'b10, 1, NONE, 10, 100, 1'b0, 1'b1);
    do_cmd(2'b01, 1, 15, 15, 100, 1'b0, 1'b1);
    // Abort while still issuing.
    do_cmd(2'b11, 5, 20, 2, 70, 1'b0, 1'b1);
    idle_gap(4);

    // Reset in the middle of a command.
    do_cmd(2'b01, 1, 4, NONE, 50, 1'b0, 1'b1);
    req_i = 2'b01; tick_i = 1'b1;
    cyc();
    chk("rst_pre_commit", eng_commit_o, 1);
    req_i = 2'b00; eng_busy_i = 1'b1;
    cyc();
    cyc();
    @(posedge clk_i);
    #2 rstn_i = 1'b0;
    #1;
    chk_all_zero("async_rst");
    eng_busy_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk("rst_hold_ack", ack_o, 0);
      chk("rst_hold_busy", busy_o, 0);
    end
    #2 rstn_i = 1'b1;
    cyc();
    chk("rst_rel_ack", ack_o, 0);
    chk("rst_rel_busy", busy_o, 0);
    pri = 1'b0;
    do_cmd(2'b11, 0, 6, NONE, 60, 1'b0, 1'b1);
    do_cmd(2'b10, 2, 9, NONE, 60, 1'b0, 1'b1);

    // Randomized commands.
    for (int i = 0; i < 25; i++) begin
      logic [1:0] rq;
      int b, e, a;
      rq = 2'($urandom_range(1, 3));
      b  = $urandom_range(0, 5);
      e  = ($urandom_range(0, 3) == 0) ? NONE : b + 1 + int'($urandom_range(0, 40));
      a  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 50)) : NONE;
      do_cmd(rq, b, e, a, $urandom_range(30, 100), 1'($urandom_range(0, 1)), 1'b1);
      idle_gap($urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
